br_cond_unit: RTL and testbench

- Consumer end of the program-status interface: holds the 5-bit status flags produced by the PSR.
- Tracks flag-writing instructions still in flight.
- Resolves conditional branches from decode against the committed flags.
- Sits between decode (branch request handshake) and fetch (taken/flush/redirect); stalls a branch until every older flag producer has written back.

---
 rtl/psr_pkg.sv | 35 +++
 rtl/cond_eval.sv | 32 +++
 rtl/br_cond_unit.sv | 116 +++++++++++
 tb/tb_br_cond_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/psr_pkg.sv
// Shared definitions for the program-status consumer side.
//   - Flag bit positions inside the 5-bit program status word.
//   - Branch condition codes understood by cond_eval.
//   - State encoding of the branch resolution FSM in br_cond_unit.
package psr_pkg;

    localparam int FLAG_W    = 5;
    localparam int FLG_PAR   = 0;
    localparam int FLG_EVEN  = 1;
    localparam int FLG_ZERO  = 2;
    localparam int FLG_POS   = 3;
    localparam int FLG_CARRY = 4;

    localparam int COND_W = 4;

    localparam logic [COND_W-1:0] COND_ALWAYS = 4'd0;
    localparam logic [COND_W-1:0] COND_PAR    = 4'd1;
    localparam logic [COND_W-1:0] COND_NPAR   = 4'd2;
    localparam logic [COND_W-1:0] COND_EVEN   = 4'd3;
    localparam logic [COND_W-1:0] COND_ODD    = 4'd4;
    localparam logic [COND_W-1:0] COND_Z      = 4'd5;
    localparam logic [COND_W-1:0] COND_NZ     = 4'd6;
    localparam logic [COND_W-1:0] COND_POS    = 4'd7;
    localparam logic [COND_W-1:0] COND_NPOS   = 4'd8;
    localparam logic [COND_W-1:0] COND_C      = 4'd9;
    localparam logic [COND_W-1:0] COND_NC     = 4'd10;
    // Codes 11..15 are reserved and always resolve not-taken.
    localparam logic [COND_W-1:0] COND_NEVER  = 4'd15;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EVAL = 1'b1
    } br_state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch condition evaluator.
// Ports:
//   flags - committed program status flags
//   cond  - condition code (see psr_pkg COND_*)
//   take  - 1 when the condition holds for the given flags
module cond_eval
    import psr_pkg::*;
(
    input  logic [FLAG_W-1:0] flags,
    input  logic [COND_W-1:0] cond,
    output logic              take
);

    always_comb begin
        take = 1'b0;
        case (cond)
            COND_ALWAYS: take = 1'b1;
            COND_PAR:    take =  flags[FLG_PAR];
            COND_NPAR:   take = ~flags[FLG_PAR];
            COND_EVEN:   take =  flags[FLG_EVEN];
            COND_ODD:    take = ~flags[FLG_EVEN];
            COND_Z:      take =  flags[FLG_ZERO];
            COND_NZ:     take = ~flags[FLG_ZERO];
            COND_POS:    take =  flags[FLG_POS];
            COND_NPOS:   take = ~flags[FLG_POS];
            COND_C:      take =  flags[FLG_CARRY];
            COND_NC:     take = ~flags[FLG_CARRY];
            default:     take = 1'b0;
        endcase
    end

endmodule

// File: rtl/br_cond_unit.sv
// Conditional branch resolution unit.
// Holds the committed status flags, counts flag-producing instructions that
// have issued but not yet written back, and resolves branches from decode
// once every older flag producer has written back.
// Ports:
//   clk, rst        - clock (rising edge), asynchronous active-high reset
//   flag_we         - flag producer writeback; captures program_status
//   program_status  - new flag values
//   flag_pend_inc   - decode issued a flag producer
//   pend_full       - in-flight counter saturated
//   br_valid/br_ready, br_cond, br_target - branch request from decode
//   resolve_valid, taken, flush, redirect_pc - registered result to fetch
//   flags_q         - committed flags
module br_cond_unit
    import psr_pkg::*;
#(
    parameter int PEND_W = 2,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flag_we,
    input  logic [FLAG_W-1:0] program_status,
    input  logic              flag_pend_inc,
    output logic              pend_full,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [COND_W-1:0] br_cond,
    input  logic [ADDR_W-1:0] br_target,
    output logic              resolve_valid,
    output logic              taken,
    output logic              flush,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [FLAG_W-1:0] flags_q
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    br_state_e         state;
    logic [PEND_W-1:0] pend_cnt;
    logic [COND_W-1:0] cond_q;
    logic [ADDR_W-1:0] target_q;
    logic              take;

    // Committed flags: last value written back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else if (flag_we) begin
            flags_q <= program_status;
        end
    end

    // In-flight flag producers. Issue and writeback in the same cycle cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_cnt <= '0;
        end else if (flag_pend_inc && !flag_we) begin
            if (pend_cnt != PEND_MAX) pend_cnt <= pend_cnt + 1'b1;
        end else if (flag_we && !flag_pend_inc) begin
            if (pend_cnt != '0) pend_cnt <= pend_cnt - 1'b1;
        end
    end

    assign pend_full = (pend_cnt == PEND_MAX);

    cond_eval u_cond_eval (
        .flags (flags_q),
        .cond  (cond_q),
        .take  (take)
    );

    // Handshake: a branch transfers on any rising edge where br_valid and
    // br_ready are both high; br_cond/br_target are sampled only on that edge.
    // br_ready depends only on state, never on br_valid.
    assign br_ready = (state == ST_IDLE);

    // Branch FSM. Result outputs are single-cycle pulses, except redirect_pc
    // which keeps the last taken target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            cond_q        <= '0;
            target_q      <= '0;
            resolve_valid <= 1'b0;
            taken         <= 1'b0;
            flush         <= 1'b0;
            redirect_pc   <= '0;
        end else begin
            resolve_valid <= 1'b0;
            taken         <= 1'b0;
            flush         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (br_valid) begin
                        cond_q   <= br_cond;
                        target_q <= br_target;
                        state    <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    // Stall until every older flag producer has written back.
                    if (pend_cnt == '0) begin
                        resolve_valid <= 1'b1;
                        taken         <= take;
                        flush         <= take;
                        if (take) redirect_pc <= target_q;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_br_cond_unit.sv
module tb_br_cond_unit;

  localparam int PEND_W = 2;
  localparam int ADDR_W = 32;
  localparam int PMAX   = (1 << PEND_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              flag_we = 1'b0;
  logic [4:0]        program_status = '0;
  logic              flag_pend_inc = 1'b0;
  logic              pend_full;
  logic              br_valid = 1'b0;
  logic              br_ready;
  logic [3:0]        br_cond = '0;
  logic [ADDR_W-1:0] br_target = '0;
  logic              resolve_valid;
  logic              taken;
  logic              flush;
  logic [ADDR_W-1:0] redirect_pc;
  logic [4:0]        flags_q;

  br_cond_unit #(.PEND_W(PEND_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .flag_we        (flag_we),
    .program_status (program_status),
    .flag_pend_inc  (flag_pend_inc),
    .pend_full      (pend_full),
    .br_valid       (br_valid),
    .br_ready       (br_ready),
    .br_cond        (br_cond),
    .br_target      (br_target),
    .resolve_valid  (resolve_valid),
    .taken          (taken),
    .flush          (flush),
    .redirect_pc    (redirect_pc),
    .flags_q        (flags_q)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Branch outcome straight from the condition table: code 0 always, codes
  // 1..10 pair up on flag bit (code-1)/2 with odd codes testing the bit set.
  function automatic logic take_ref(input logic [4:0] f, input int c);
    if (c == 0) return 1'b1;
    if (c > 10) return 1'b0;
    if ((c % 2) == 1) return f[(c - 1) / 2];
    return !f[(c - 1) / 2];
  endfunction

  int          m_cnt = 0;
  logic        m_busy = 1'b0;
  int          m_cond = 0;
  logic [31:0] m_target = '0;
  logic [31:0] m_pc = '0;
  logic [4:0]  m_flags = '0;
  logic        m_rv = 1'b0, m_tk = 1'b0, m_fl = 1'b0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_cnt = 0; m_busy = 1'b0; m_cond = 0; m_target = '0; m_pc = '0;
        m_flags = '0; m_rv = 1'b0; m_tk = 1'b0; m_fl = 1'b0;
      end else begin
        logic t;
        if (m_busy && m_cnt == 0) begin
          t = take_ref(m_flags, m_cond);
          m_rv = 1'b1; m_tk = t; m_fl = t;
          if (t) m_pc = m_target;
          m_busy = 1'b0;
        end else begin
          m_rv = 1'b0; m_tk = 1'b0; m_fl = 1'b0;
          if (!m_busy && br_valid) begin
            m_busy = 1'b1; m_cond = int'(br_cond); m_target = br_target;
          end
        end
        if (flag_we) m_flags = program_status;
        m_cnt = m_cnt + int'(flag_pend_inc) - int'(flag_we);
        if (m_cnt < 0) m_cnt = 0;
        if (m_cnt > PMAX) m_cnt = PMAX;
      end
    end
  end

  // ---------------- scoreboard compare (opposite edge) ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("resolve_valid", 32'(resolve_valid), 32'(m_rv));
      chk("taken",         32'(taken),         32'(m_tk));
      chk("flush",         32'(flush),         32'(m_fl));
      chk("redirect_pc",   redirect_pc,        m_pc);
      chk("flags_q",       32'(flags_q),       32'(m_flags));
      chk("br_ready",      32'(br_ready),      32'(!m_busy));
      chk("pend_full",     32'(pend_full),     32'(m_cnt == PMAX));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_flags(input logic [4:0] ps);
    flag_we = 1'b1; program_status = ps;
    cyc();
    flag_we = 1'b0;
  endtask

  task automatic issue(input int n);
    flag_pend_inc = 1'b1;
    repeat (n) cyc();
    flag_pend_inc = 1'b0;
  endtask

  task automatic accept(input logic [3:0] c, input logic [31:0] tgt);
    br_valid = 1'b1; br_cond = c; br_target = tgt;
    cyc();
    br_valid = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    #1 rst = 1'b1;
    repeat (2) cyc();
    chk("reset_rv", 32'(resolve_valid), 32'h0);
    chk("reset_ready", 32'(br_ready), 32'h1);
    chk("reset_pc", redirect_pc, 32'h0);
    rst = 1'b0;
    cyc();

    // Z branch on zero flags: result two edges after accept.
    write_flags(5'b00100);
    accept(4'd5, 32'h40);
    chk("z_ready_eval", 32'(br_ready), 32'h0);
    cyc();
    chk("z_rv", 32'(resolve_valid), 32'h1);
    chk("z_taken", 32'(taken), 32'h1);
    chk("z_flush", 32'(flush), 32'h1);
    chk("z_pc", redirect_pc, 32'h40);
    cyc();
    chk("z_rv_pulse", 32'(resolve_valid), 32'h0);

    // NZ branch waits for two producers; second writeback clears Z.
    issue(2);
    accept(4'd6, 32'h80);
    chk("nz_stall_ready", 32'(br_ready), 32'h0);
    cyc();
    chk("nz_stall_rv0", 32'(resolve_valid), 32'h0);
    write_flags(5'b00100);
    cyc();
    chk("nz_stall_rv1", 32'(resolve_valid), 32'h0);
    write_flags(5'b01000);
    chk("nz_rv_early", 32'(resolve_valid), 32'h0);
    cyc();
    chk("nz_rv", 32'(resolve_valid), 32'h1);
    chk("nz_taken", 32'(taken), 32'h1);
    chk("nz_pc", redirect_pc, 32'h80);

    // Simultaneous issue/writeback, saturation, then drain.
    issue(1);
    accept(4'd0, 32'hC0);
    flag_pend_inc = 1'b1; flag_we = 1'b1; program_status = 5'b10000;
    cyc();
    flag_pend_inc = 1'b0; flag_we = 1'b0;
    chk("sim_stall_ready", 32'(br_ready), 32'h0);
    chk("sim_stall_rv", 32'(resolve_valid), 32'h0);
    chk("sim_full0", 32'(pend_full), 32'h0);
    issue(3);
    chk("sat_full", 32'(pend_full), 32'h1);
    issue(1);
    chk("sat_full_hold", 32'(pend_full), 32'h1);
    flag_we = 1'b1;
    cyc();
    chk("drain_full0", 32'(pend_full), 32'h0);
    cyc();
    cyc();
    flag_we = 1'b0;
    chk("drain_rv0", 32'(resolve_valid), 32'h0);
    cyc();
    chk("drain_rv", 32'(resolve_valid), 32'h1);
    chk("drain_pc", redirect_pc, 32'hC0);

    // Not-taken: C with carry clear, then reserved code.
    write_flags(5'b01111);
    accept(4'd9, 32'h100);
    cyc();
    chk("c_rv", 32'(resolve_valid), 32'h1);
    chk("c_taken", 32'(taken), 32'h0);
    chk("c_flush", 32'(flush), 32'h0);
    chk("c_pc_hold", redirect_pc, 32'hC0);
    write_flags(5'b11111);
    accept(4'd13, 32'h200);
    cyc();
    chk("rsv_rv", 32'(resolve_valid), 32'h1);
    chk("rsv_taken", 32'(taken), 32'h0);
    chk("rsv_pc_hold", redirect_pc, 32'hC0);

    // Back-to-back: accepts at T and T+2; the target offered at T+1 is ignored.
    br_valid = 1'b1; br_cond = 4'd0; br_target = 32'h400;
    cyc();
    br_target = 32'h500;
    cyc();
    chk("b2b_rv1", 32'(resolve_valid), 32'h1);
    chk("b2b_pc1", redirect_pc, 32'h400);
    chk("b2b_ready", 32'(br_ready), 32'h1);
    br_target = 32'h600;
    cyc();
    br_valid = 1'b0;
    cyc();
    chk("b2b_rv2", 32'(resolve_valid), 32'h1);
    chk("b2b_pc2", redirect_pc, 32'h600);

    // Asynchronous reset while stalled in evaluation with two pending.
    issue(2);
    accept(4'd0, 32'h300);
    #2 rst = 1'b1;
    #1;
    chk("arst_rv", 32'(resolve_valid), 32'h0);
    chk("arst_taken", 32'(taken), 32'h0);
    chk("arst_flush", 32'(flush), 32'h0);
    chk("arst_flags", 32'(flags_q), 32'h0);
    chk("arst_ready", 32'(br_ready), 32'h1);
    chk("arst_full", 32'(pend_full), 32'h0);
    chk("arst_pc", redirect_pc, 32'h0);
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    chk("arst_dropped", 32'(resolve_valid), 32'h0);

    // Every flag value against every condition code.
    for (int f = 0; f < 32; f++) begin
      write_flags(5'(f));
      for (int c = 0; c < 16; c++) begin
        accept(4'(c), 32'(f * 16 + c + 1));
        cyc();
        chk("exh_taken", 32'(taken), 32'(take_ref(5'(f), c)));
      end
    end

    // Random traffic, occasional asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      br_valid       = 1'($urandom_range(0, 1));
      br_cond        = 4'($urandom_range(0, 15));
      br_target      = $urandom;
      flag_we        = ($urandom_range(0, 3) == 0);
      program_status = 5'($urandom_range(0, 31));
      flag_pend_inc  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
      cyc();
      rst = 1'b0;
    end
    br_valid = 1'b0; flag_we = 1'b0; flag_pend_inc = 1'b0;
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
